// File: rtl/task_ctrl_pkg.sv
// Shared state encodings for the task group controller.
// Child encoding is fixed to stay compatible with existing blocks.
package task_ctrl_pkg;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] C_IDLE  = 2'b00;
  localparam logic [ST_W-1:0] C_START = 2'b01;
  localparam logic [ST_W-1:0] C_RUN   = 2'b11;
  localparam logic [ST_W-1:0] C_DONE  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } top_state_t;

endpackage

// File: rtl/task_child_fsm.sv
// Per-child ap_ctrl_hs handshake tracker.
// Issues one start, waits for ready, then waits for done.
module task_child_fsm
  import task_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic global_start,
  input  logic global_done,
  input  logic detached,
  input  logic ap_ready,
  input  logic ap_done,
  output logic ap_start,
  output logic is_done
);

  logic [ST_W-1:0] state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= C_IDLE;
      ap_start <= 1'b0;
      is_done  <= 1'b0;
    end else begin
      case (state)
        C_IDLE: begin
          if (global_start) begin
            state    <= C_START;
            ap_start <= 1'b1;
          end
        end
        C_START: begin
          if (ap_ready) begin
            ap_start <= 1'b0;
            if (ap_done) begin
              state   <= C_DONE;
              is_done <= 1'b1;
            end else begin
              state <= C_RUN;
            end
          end
        end
        C_RUN: begin
          if (ap_done) begin
            state   <= C_DONE;
            is_done <= 1'b1;
          end
        end
        C_DONE: begin
          // detached children never hold up the group
          if (detached || global_done) begin
            state   <= C_IDLE;
            is_done <= 1'b0;
          end
        end
        default: begin
          state    <= C_IDLE;
          ap_start <= 1'b0;
          is_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/task_group_fsm.sv
// Group controller: one ap_ctrl_hs front end fanning out to
// NUM_TASKS child tasks, with drain delay and run-cycle counter.
module task_group_fsm
  import task_ctrl_pkg::*;
#(
  parameter int          NUM_TASKS   = 2,
  parameter int          NUM_SCALARS = 4,
  parameter int          SCALAR_W    = 64,
  parameter logic [31:0] DETACH_MASK = '0,
  parameter int          DONE_DELAY  = 0,
  parameter int          CNT_W       = 32
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst,
  input  logic                            ap_start,
  output logic                            ap_ready,
  output logic                            ap_done,
  output logic                            ap_idle,
  input  logic [NUM_SCALARS*SCALAR_W-1:0] scalars_in,
  output logic [NUM_SCALARS*SCALAR_W-1:0] child_scalars,
  output logic [NUM_TASKS-1:0]            child_ap_start,
  input  logic [NUM_TASKS-1:0]            child_ap_ready,
  input  logic [NUM_TASKS-1:0]            child_ap_done,
  input  logic [NUM_TASKS-1:0]            child_ap_idle,
  output logic [CNT_W-1:0]                run_cycles
);

  localparam logic [7:0] DRAIN_INIT =
    (DONE_DELAY > 0) ? 8'(DONE_DELAY - 1) : 8'd0;

  localparam logic [NUM_TASKS-1:0] DMASK =
    DETACH_MASK[NUM_TASKS-1:0];

  top_state_t           state;
  logic [7:0]           countdown;
  logic [NUM_TASKS-1:0] child_done;
  logic                 global_start;
  logic                 global_done;
  logic                 all_done;
  logic                 unused_idle;

  assign unused_idle  = ^child_ap_idle;
  assign global_start = (state == IDLE) && ap_start;
  assign global_done  = (state == DONE);
  assign all_done     = &(child_done | DMASK);
  assign ap_ready     = ap_done;

  for (genvar i = 0; i < NUM_TASKS; i++) begin : g_child
    task_child_fsm u_child (
      .clk          (ap_clk),
      .rst          (ap_rst),
      .global_start (global_start),
      .global_done  (global_done),
      .detached     (DMASK[i]),
      .ap_ready     (child_ap_ready[i]),
      .ap_done      (child_ap_done[i]),
      .ap_start     (child_ap_start[i]),
      .is_done      (child_done[i])
    );
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state         <= IDLE;
      ap_done       <= 1'b0;
      ap_idle       <= 1'b1;
      countdown     <= '0;
      run_cycles    <= '0;
      child_scalars <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ap_start) begin
            state         <= RUN;
            ap_idle       <= 1'b0;
            child_scalars <= scalars_in;
            run_cycles    <= '0;
          end
        end
        RUN: begin
          if (~&run_cycles) run_cycles <= run_cycles + 1'b1;
          if (all_done) begin
            if (DONE_DELAY > 0) begin
              state     <= DRAIN;
              countdown <= DRAIN_INIT;
            end else begin
              state   <= DONE;
              ap_done <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (~&run_cycles) run_cycles <= run_cycles + 1'b1;
          if (countdown == 8'd0) begin
            state   <= DONE;
            ap_done <= 1'b1;
          end else begin
            countdown <= countdown - 8'd1;
          end
        end
        DONE: begin
          state   <= IDLE;
          ap_done <= 1'b0;
          ap_idle <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ap_done <= 1'b0;
          ap_idle <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_task_group_fsm.sv
// Directed bench for task_group_fsm: three instances cover
// plain, drain-delay and detached-child configurations.
module tb_task_group_fsm;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  logic [255:0] sc_a, sc_b, sc_in;

  // u0: delay 0, no detach
  logic         st0, rdy0, done0, idle0;
  logic [255:0] cs0;
  logic [1:0]   cst0, r0, d0;
  logic [31:0]  rc0;
  // u1: delay 3
  logic         st1, rdy1, done1, idle1;
  logic [255:0] cs1;
  logic [1:0]   cst1, r1, d1;
  logic [31:0]  rc1;
  // u2: child1 detached
  logic         st2, rdy2, done2, idle2;
  logic [255:0] cs2;
  logic [1:0]   cst2, r2, d2;
  logic [31:0]  rc2;

  task_group_fsm #(.DONE_DELAY(0)) u0 (
    .ap_clk(clk), .ap_rst(rst), .ap_start(st0),
    .ap_ready(rdy0), .ap_done(done0), .ap_idle(idle0),
    .scalars_in(sc_in), .child_scalars(cs0),
    .child_ap_start(cst0), .child_ap_ready(r0),
    .child_ap_done(d0), .child_ap_idle(2'b00),
    .run_cycles(rc0)
  );

  task_group_fsm #(.DONE_DELAY(3)) u1 (
    .ap_clk(clk), .ap_rst(rst), .ap_start(st1),
    .ap_ready(rdy1), .ap_done(done1), .ap_idle(idle1),
    .scalars_in(sc_in), .child_scalars(cs1),
    .child_ap_start(cst1), .child_ap_ready(r1),
    .child_ap_done(d1), .child_ap_idle(2'b00),
    .run_cycles(rc1)
  );

  task_group_fsm #(.DETACH_MASK(32'h2)) u2 (
    .ap_clk(clk), .ap_rst(rst), .ap_start(st2),
    .ap_ready(rdy2), .ap_done(done2), .ap_idle(idle2),
    .scalars_in(sc_in), .child_scalars(cs2),
    .child_ap_start(cst2), .child_ap_ready(r2),
    .child_ap_done(d2), .child_ap_idle(2'b00),
    .run_cycles(rc2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    sc_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    sc_b = {64'hdddd_dddd_dddd_dddd, 64'hcccc_cccc_cccc_cccc,
            64'hbbbb_bbbb_bbbb_bbbb, 64'haaaa_aaaa_aaaa_aaaa};
    rst = 1'b1;
    sc_in = '0;
    st0 = 0; r0 = 0; d0 = 0;
    st1 = 0; r1 = 0; d1 = 0;
    st2 = 0; r2 = 0; d2 = 0;
    tick();
    tick();
    chk("rst_idle", idle0, 1);
    chk("rst_done", done0, 0);
    chk("rst_ready", rdy0, 0);
    chk("rst_cst", cst0, 0);
    chk("rst_rc", rc0, 0);
    chk("rst_cs", cs0, 0);
    chk("rst_idle_u2", idle2, 1);
    rst = 1'b0;
    tick();

    // basic run with scalar latching
    sc_in = sc_a;
    st0 = 1;
    tick();                           // cycle 1
    st0 = 0;
    sc_in = sc_b;
    chk("t1_cst_c1", cst0, 2'b11);
    chk("t1_idle_c1", idle0, 0);
    r0 = 2'b11; d0 = 2'b01;
    tick();                           // cycle 2
    r0 = 0; d0 = 0;
    chk("t1_cst_c2", cst0, 2'b00);
    st0 = 1;                          // ignored in RUN
    tick();                           // cycle 3
    chk("t1_restart_ign", cst0, 2'b00);
    st0 = 0;
    tick();                           // cycle 4
    tick();                           // cycle 5
    d0 = 2'b10;
    tick();                           // cycle 6
    d0 = 0;
    chk("t1_done_c6", done0, 0);
    tick();                           // cycle 7
    chk("t1_done_c7", done0, 1);
    chk("t1_ready_c7", rdy0, 1);
    chk("t1_rc", rc0, 6);
    chk("t1_scalars", cs0, sc_a);
    st0 = 1;                          // ignored in DONE
    tick();                           // cycle 8
    st0 = 0;
    chk("t1_done_c8", done0, 0);
    chk("t1_idle_c8", idle0, 1);
    chk("t1_rc_hold", rc0, 6);
    chk("t1_no_start_done", cst0, 2'b00);
    tick();
    chk("t1_stay_idle", idle0, 1);

    // ready held low for 10 cycles
    st0 = 1;
    tick();
    st0 = 0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t2_hold_%0d", i), cst0, 2'b11);
      if (i == 3) st0 = 1;
      if (i == 4) st0 = 0;
      if (i == 9) begin r0 = 2'b11; d0 = 2'b11; end
      tick();
    end
    r0 = 0; d0 = 0;
    chk("t2_cst_off", cst0, 2'b00);
    chk("t2_not_done", done0, 0);
    tick();
    chk("t2_done", done0, 1);
    chk("t2_rc", rc0, 11);
    chk("t2_scalars", cs0, sc_b);
    tick();
    chk("t2_idle", idle0, 1);

    // reset in the middle of a run
    st0 = 1;
    tick();
    st0 = 0;
    chk("t3_cst_c1", cst0, 2'b11);
    tick();
    chk("t3_rc_c2", rc0, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("t3_rst_cst", cst0, 2'b00);
    chk("t3_rst_idle", idle0, 1);
    chk("t3_rst_rc", rc0, 0);
    chk("t3_rst_cs", cs0, 0);
    sc_in = sc_a;
    st0 = 1;
    tick();                           // cycle 1
    st0 = 0;
    r0 = 2'b11; d0 = 2'b11;
    tick();                           // cycle 2
    r0 = 0; d0 = 0;
    chk("t3_min_c2", done0, 0);
    tick();                           // cycle 3
    chk("t3_min_c3", done0, 1);
    chk("t3_min_rc", rc0, 2);
    chk("t3_cs", cs0, sc_a);
    tick();

    // drain delay of 3
    st1 = 1;
    tick();                           // cycle 1
    st1 = 0;
    chk("t4_cst", cst1, 2'b11);
    tick();                           // cycle 2
    r1 = 2'b11; d1 = 2'b11;
    tick();                           // cycle 3
    r1 = 0; d1 = 0;
    tick();                           // cycle 4
    chk("t4_c4", done1, 0);
    tick();                           // cycle 5
    tick();                           // cycle 6
    chk("t4_c6", done1, 0);
    chk("t4_c6_idle", idle1, 0);
    tick();                           // cycle 7
    chk("t4_c7", done1, 1);
    chk("t4_rc", rc1, 6);
    tick();
    chk("t4_idle", idle1, 1);

    // detached child1, never completes
    st2 = 1;
    tick();                           // cycle 1
    st2 = 0;
    chk("t5_cst_c1", cst2, 2'b11);
    r2 = 2'b01; d2 = 2'b01;
    tick();                           // cycle 2
    r2 = 0; d2 = 0;
    chk("t5_c2", done2, 0);
    tick();                           // cycle 3
    chk("t5_done", done2, 1);
    chk("t5_c1_start", cst2, 2'b10);
    tick();                           // cycle 4
    chk("t5_idle", idle2, 1);
    st2 = 1;
    tick();                           // cycle 5
    st2 = 0;
    chk("t5_restart", cst2, 2'b11);
    r2 = 2'b10;
    tick();                           // cycle 6
    chk("t5_c1_ready", cst2, 2'b01);
    r2 = 2'b01; d2 = 2'b11;
    tick();                           // cycle 7
    r2 = 0; d2 = 0;
    chk("t5_c7", cst2, 2'b00);
    tick();                           // cycle 8
    chk("t5_done2", done2, 1);
    tick();                           // cycle 9
    st2 = 1;
    tick();                           // cycle 10
    st2 = 0;
    chk("t5_both_again", cst2, 2'b11);
    r2 = 2'b11; d2 = 2'b11;
    tick();
    r2 = 0; d2 = 0;
    tick();
    chk("t5_done3", done2, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
